// File: rtl/clint_trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clint_trap_ctrl_pkg
// Purpose : Shared definitions for the core-local trap controller and the
//           CSR register file: CSR addresses, trap cause codes, mstatus bit
//           positions and the trap/return sequencer state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package clint_trap_ctrl_pkg;

  // CSR addresses, shared with the CSR register file
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  // mcause values
  localparam logic [31:0] CAUSE_ECALL_M    = 32'h0000_000B;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'h0000_0003;
  localparam logic [31:0] CAUSE_M_TIMER    = 32'h8000_0007;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Sequencer states: T_* walk a trap entry, R_* walk an MRET
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_MEPC   = 3'd1,
    T_MCAUSE = 3'd2,
    T_MSTAT  = 3'd3,
    T_JUMP   = 3'd4,
    R_MSTAT  = 3'd5,
    R_JUMP   = 3'd6
  } state_t;

endpackage : clint_trap_ctrl_pkg
`default_nettype wire

// File: rtl/clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clint_trap_ctrl
// Purpose : Core-local interrupt/trap controller. Detects ECALL, EBREAK, MRET
//           and the machine timer interrupt in ID, then issues the mepc,
//           mcause and mstatus updates one per cycle on the CSR file's second
//           write port before redirecting fetch. The pipeline is held for
//           the whole sequence.
// Ports   : clk, rst (sync, active-low)
//           id_valid/id_pc/id_ecall/id_ebreak/id_mret - ID stage decode
//           interrupt_flag, interrupt_enable            - timer request, MIE
//           csr_we_ex                                   - EX owns CSR port
//           csr_mstatus/csr_mepc/csr_mtvec              - current CSR values
//           we_clint/wa_clint/wd_clint                  - CSR write port
//           clint_hold, clint_jump, clint_jump_addr     - pipeline control
// Revision: 1.0 - initial release
// ============================================================================
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              id_ecall,
  input  logic              id_ebreak,
  input  logic              id_mret,
  input  logic              interrupt_flag,
  input  logic              csr_we_ex,
  input  logic [XLEN-1:0]   csr_mstatus,
  input  logic [XLEN-1:0]   csr_mepc,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic              interrupt_enable,
  output logic              we_clint,
  output logic [CSR_AW-1:0] wa_clint,
  output logic [XLEN-1:0]   wd_clint,
  output logic              clint_hold,
  output logic              clint_jump,
  output logic [XLEN-1:0]   clint_jump_addr
);

  state_t            state;
  state_t            state_next;
  logic              pending;
  logic [XLEN-1:0]   saved_pc;
  logic [XLEN-1:0]   saved_cause;

  logic              capture;
  logic              int_accept;
  logic [XLEN-1:0]   cause_sel;
  logic              int_req;
  logic [XLEN-1:0]   vec_base;

  // A request latched in an earlier cycle counts as well as a live one
  assign int_req  = (pending | interrupt_flag) & interrupt_enable;
  assign vec_base = {csr_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    state_next      = state;
    capture         = 1'b0;
    int_accept      = 1'b0;
    cause_sel       = '0;
    we_clint        = 1'b0;
    wa_clint        = '0;
    wd_clint        = '0;
    clint_hold      = 1'b0;
    clint_jump      = 1'b0;
    clint_jump_addr = '0;

    case (state)
      IDLE: begin
        if (id_valid) begin
          if (id_ecall) begin
            capture   = 1'b1;
            cause_sel = XLEN'(CAUSE_ECALL_M);
          end else if (id_ebreak) begin
            capture   = 1'b1;
            cause_sel = XLEN'(CAUSE_BREAKPOINT);
          end else if (id_mret) begin
            state_next = R_MSTAT;
            clint_hold = 1'b1;
          end else if (int_req) begin
            capture    = 1'b1;
            int_accept = 1'b1;
            cause_sel  = XLEN'(CAUSE_M_TIMER);
          end
        end
        if (capture) begin
          state_next = T_MEPC;
          clint_hold = 1'b1;
        end
      end

      // Write states yield to EX and retry until the port is free
      T_MEPC: begin
        clint_hold = 1'b1;
        we_clint   = ~csr_we_ex;
        if (!csr_we_ex) begin
          wa_clint   = CSR_AW'(CSR_MEPC);
          wd_clint   = saved_pc;
          state_next = T_MCAUSE;
        end
      end

      T_MCAUSE: begin
        clint_hold = 1'b1;
        we_clint   = ~csr_we_ex;
        if (!csr_we_ex) begin
          wa_clint   = CSR_AW'(CSR_MCAUSE);
          wd_clint   = saved_cause;
          state_next = T_MSTAT;
        end
      end

      T_MSTAT: begin
        clint_hold = 1'b1;
        we_clint   = ~csr_we_ex;
        if (!csr_we_ex) begin
          wa_clint               = CSR_AW'(CSR_MSTATUS);
          wd_clint               = csr_mstatus;
          wd_clint[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
          wd_clint[MSTATUS_MIE]  = 1'b0;
          state_next             = T_JUMP;
        end
      end

      T_JUMP: begin
        clint_hold = 1'b1;
        clint_jump = 1'b1;
        // Vectored mode only offsets asynchronous causes
        if (csr_mtvec[1:0] == 2'b01 && saved_cause[XLEN-1])
          clint_jump_addr = vec_base + {saved_cause[XLEN-3:0], 2'b00};
        else
          clint_jump_addr = vec_base;
        state_next = IDLE;
      end

      R_MSTAT: begin
        clint_hold = 1'b1;
        we_clint   = ~csr_we_ex;
        if (!csr_we_ex) begin
          wa_clint               = CSR_AW'(CSR_MSTATUS);
          wd_clint               = csr_mstatus;
          wd_clint[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
          wd_clint[MSTATUS_MPIE] = 1'b1;
          state_next             = R_JUMP;
        end
      end

      R_JUMP: begin
        clint_hold      = 1'b1;
        clint_jump      = 1'b1;
        clint_jump_addr = csr_mepc;
        state_next      = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // While reset is asserted nothing leaves the block
    if (!rst) begin
      we_clint        = 1'b0;
      wa_clint        = '0;
      wd_clint        = '0;
      clint_hold      = 1'b0;
      clint_jump      = 1'b0;
      clint_jump_addr = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      saved_pc    <= '0;
      saved_cause <= '0;
    end else begin
      state   <= state_next;
      // Accepting the interrupt consumes the request, even a fresh one
      pending <= int_accept ? 1'b0 : (pending | interrupt_flag);
      if (capture) begin
        saved_pc    <= id_pc;
        saved_cause <= cause_sel;
      end
    end
  end

endmodule : clint_trap_ctrl
`default_nettype wire

// File: tb/tb_clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clint_trap_ctrl
// Purpose : Self-checking bench for clint_trap_ctrl. A queue-of-actions model
//           predicts the outputs every cycle; directed scenarios add literal
//           expectations, followed by a randomized run.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_clint_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_ecall;
  logic        id_ebreak;
  logic        id_mret;
  logic        interrupt_flag;
  logic        csr_we_ex;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mtvec;
  logic        interrupt_enable;
  logic        we_clint;
  logic [11:0] wa_clint;
  logic [31:0] wd_clint;
  logic        clint_hold;
  logic        clint_jump;
  logic [31:0] clint_jump_addr;

  always #5 clk = ~clk;

  clint_trap_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_ecall         (id_ecall),
    .id_ebreak        (id_ebreak),
    .id_mret          (id_mret),
    .interrupt_flag   (interrupt_flag),
    .csr_we_ex        (csr_we_ex),
    .csr_mstatus      (csr_mstatus),
    .csr_mepc         (csr_mepc),
    .csr_mtvec        (csr_mtvec),
    .interrupt_enable (interrupt_enable),
    .we_clint         (we_clint),
    .wa_clint         (wa_clint),
    .wd_clint         (wd_clint),
    .clint_hold       (clint_hold),
    .clint_jump       (clint_jump),
    .clint_jump_addr  (clint_jump_addr)
  );

  // Model: a list of outstanding actions the controller still owes.
  localparam int K_WR   = 0;  // fixed-data CSR write
  localparam int K_TST  = 1;  // trap mstatus write (data from live mstatus)
  localparam int K_RST  = 2;  // mret mstatus write
  localparam int K_TJ   = 3;  // trap jump, data holds the cause
  localparam int K_RJ   = 4;  // mret jump to mepc

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
  } op_t;

  op_t q[$];
  bit  m_pending;
  int  checks = 0;
  int  errors = 0;

  logic        obs_we, obs_hold, obs_jump;
  logic [11:0] obs_wa;
  logic [31:0] obs_wd, obs_ja;

  function automatic op_t mk(int k, logic [11:0] a, logic [31:0] d);
    op_t o;
    o.kind = k; o.addr = a; o.data = d;
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_trap(logic [31:0] pc, logic [31:0] cause);
    q.push_back(mk(K_WR, 12'h341, pc));
    q.push_back(mk(K_WR, 12'h342, cause));
    q.push_back(mk(K_TST, 12'h300, 32'h0));
    q.push_back(mk(K_TJ, 12'h000, cause));
  endtask

  // Evaluate the model for the current cycle, compare, and advance the model
  task automatic model_check();
    logic        e_we, e_hold, e_jump;
    logic [11:0] e_wa;
    logic [31:0] e_wd, e_ja;
    op_t         h;
    bit          took_int;
    e_we = 0; e_hold = 0; e_jump = 0; e_wa = 0; e_wd = 0; e_ja = 0;
    took_int = 0;
    obs_we = we_clint; obs_wa = wa_clint; obs_wd = wd_clint;
    obs_hold = clint_hold; obs_jump = clint_jump; obs_ja = clint_jump_addr;

    if (!rst) begin
      q.delete();
      m_pending = 0;
    end else if (q.size() > 0) begin
      h = q[0];
      e_hold = 1;
      if (h.kind == K_TJ) begin
        e_jump = 1;
        e_ja   = csr_mtvec & 32'hFFFF_FFFC;
        if (csr_mtvec[1:0] == 2'b01 && h.data[31])
          e_ja = e_ja + (h.data & 32'h7FFF_FFFF) * 4;
        void'(q.pop_front());
      end else if (h.kind == K_RJ) begin
        e_jump = 1;
        e_ja   = csr_mepc;
        void'(q.pop_front());
      end else if (!csr_we_ex) begin
        e_we = 1;
        e_wa = h.addr;
        if (h.kind == K_WR)
          e_wd = h.data;
        else if (h.kind == K_TST)
          e_wd = (csr_mstatus & ~32'h88) | (csr_mstatus[3] ? 32'h80 : 32'h0);
        else
          e_wd = (csr_mstatus & ~32'h8) | (csr_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
        void'(q.pop_front());
      end
      m_pending = m_pending | interrupt_flag;
    end else begin
      if (id_valid) begin
        if (id_ecall) begin
          push_trap(id_pc, 32'h0000_000B); e_hold = 1;
        end else if (id_ebreak) begin
          push_trap(id_pc, 32'h0000_0003); e_hold = 1;
        end else if (id_mret) begin
          q.push_back(mk(K_RST, 12'h300, 32'h0));
          q.push_back(mk(K_RJ, 12'h000, 32'h0));
          e_hold = 1;
        end else if ((m_pending || interrupt_flag) && interrupt_enable) begin
          push_trap(id_pc, 32'h8000_0007); e_hold = 1; took_int = 1;
        end
      end
      m_pending = took_int ? 1'b0 : (m_pending | interrupt_flag);
    end

    chk("we_clint", {31'b0, obs_we}, {31'b0, e_we});
    chk("wa_clint", {20'b0, obs_wa}, {20'b0, e_wa});
    chk("wd_clint", obs_wd, e_wd);
    chk("clint_hold", {31'b0, obs_hold}, {31'b0, e_hold});
    chk("clint_jump", {31'b0, obs_jump}, {31'b0, e_jump});
    chk("clint_jump_addr", obs_ja, e_ja);
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_ecall = 0; id_ebreak = 0; id_mret = 0;
    interrupt_flag = 0; csr_we_ex = 0;
  endtask

  task automatic lit_w(string name, logic [11:0] a, logic [31:0] d);
    chk({name, "_we"}, {31'b0, obs_we}, 32'd1);
    chk({name, "_wa"}, {20'b0, obs_wa}, {20'b0, a});
    chk({name, "_wd"}, obs_wd, d);
  endtask

  initial begin
    m_pending = 0;
    rst = 0;
    id_pc = 32'h100; csr_mstatus = 32'h8; csr_mepc = 32'h0;
    csr_mtvec = 32'h200; interrupt_enable = 1;
    set_idle();
    // Reset held with an ECALL visible: nothing may leave the block
    id_valid = 1; id_ecall = 1; interrupt_flag = 1;
    repeat (3) cycle();
    chk("reset_hold", {31'b0, obs_hold}, 32'd0);
    chk("reset_we", {31'b0, obs_we}, 32'd0);
    rst = 1;
    set_idle();
    cycle();

    // ECALL at pc 0x100, mtvec 0x200, mstatus 0x8
    id_valid = 1; id_ecall = 1; id_pc = 32'h100;
    csr_mtvec = 32'h200; csr_mstatus = 32'h8; interrupt_enable = 1;
    cycle();
    chk("ecall_detect_hold", {31'b0, obs_hold}, 32'd1);
    set_idle();
    cycle(); lit_w("ecall_mepc", 12'h341, 32'h100);
    cycle(); lit_w("ecall_mcause", 12'h342, 32'hB);
    cycle(); lit_w("ecall_mstatus", 12'h300, 32'h80);
    csr_mstatus = 32'h80; interrupt_enable = 0;
    cycle();
    chk("ecall_jump", {31'b0, obs_jump}, 32'd1);
    chk("ecall_jump_addr", obs_ja, 32'h200);
    chk("ecall_jump_hold", {31'b0, obs_hold}, 32'd1);
    cycle();
    chk("ecall_done_hold", {31'b0, obs_hold}, 32'd0);

    // MRET with mepc 0x104, mstatus 0x80
    csr_mepc = 32'h104;
    id_valid = 1; id_mret = 1;
    cycle();
    chk("mret_detect_hold", {31'b0, obs_hold}, 32'd1);
    set_idle();
    cycle(); lit_w("mret_mstatus", 12'h300, 32'h88);
    cycle();
    chk("mret_jump_addr", obs_ja, 32'h104);
    chk("mret_jump", {31'b0, obs_jump}, 32'd1);

    // Interrupt with MIE=0 latches, then is taken once MIE=1 (vectored)
    csr_mstatus = 32'h0; interrupt_enable = 0; csr_mtvec = 32'h301;
    id_valid = 1; id_pc = 32'h500; interrupt_flag = 1;
    cycle();
    chk("int_masked_hold", {31'b0, obs_hold}, 32'd0);
    interrupt_flag = 0;
    cycle();
    chk("int_masked_hold2", {31'b0, obs_hold}, 32'd0);
    csr_mstatus = 32'h8; interrupt_enable = 1;
    cycle();
    chk("int_pending_taken", {31'b0, obs_hold}, 32'd1);
    id_valid = 0;
    cycle(); lit_w("int_mepc", 12'h341, 32'h500);
    cycle(); lit_w("int_mcause", 12'h342, 32'h8000_0007);
    cycle(); lit_w("int_mstatus", 12'h300, 32'h80);
    cycle();
    chk("int_vec_addr", obs_ja, 32'h31C);
    id_valid = 1;
    cycle();
    chk("int_pending_cleared", {31'b0, obs_hold}, 32'd0);

    // ECALL in vectored mode goes to the base
    id_ecall = 1; id_pc = 32'h600;
    cycle();
    set_idle();
    repeat (3) cycle();
    cycle();
    chk("ecall_vec_addr", obs_ja, 32'h300);

    // EX steals the write port for two cycles during T_MCAUSE
    csr_mtvec = 32'h200;
    id_valid = 1; id_ecall = 1; id_pc = 32'h40;
    cycle();
    set_idle();
    cycle(); lit_w("cont_mepc", 12'h341, 32'h40);
    csr_we_ex = 1;
    cycle();
    chk("cont_stall1_we", {31'b0, obs_we}, 32'd0);
    cycle();
    chk("cont_stall2_we", {31'b0, obs_we}, 32'd0);
    chk("cont_stall2_hold", {31'b0, obs_hold}, 32'd1);
    csr_we_ex = 0;
    cycle(); lit_w("cont_mcause", 12'h342, 32'hB);
    cycle(); lit_w("cont_mstatus", 12'h300, 32'h80);
    cycle();
    chk("cont_jump", {31'b0, obs_jump}, 32'd1);

    // Reset during T_MCAUSE abandons the sequence
    id_valid = 1; id_ecall = 1; id_pc = 32'h80;
    cycle();
    set_idle();
    cycle(); lit_w("rst_mepc", 12'h341, 32'h80);
    rst = 0;
    cycle();
    chk("rst_mid_we", {31'b0, obs_we}, 32'd0);
    chk("rst_mid_hold", {31'b0, obs_hold}, 32'd0);
    rst = 1;
    cycle();
    chk("rst_after_we", {31'b0, obs_we}, 32'd0);
    chk("rst_after_hold", {31'b0, obs_hold}, 32'd0);
    id_valid = 1; id_ecall = 1; id_pc = 32'h90;
    cycle();
    set_idle();
    cycle(); lit_w("rst_re_mepc", 12'h341, 32'h90);
    repeat (2) cycle();
    cycle();
    chk("rst_re_jump", {31'b0, obs_jump}, 32'd1);

    // ECALL together with a fresh interrupt: ECALL first, interrupt after
    interrupt_enable = 1;
    id_valid = 1; id_ecall = 1; id_pc = 32'hA0; interrupt_flag = 1;
    cycle();
    set_idle();
    repeat (2) cycle();
    lit_w("both_ecall_mcause", 12'h342, 32'hB);
    repeat (2) cycle();
    id_valid = 1; id_pc = 32'hB0;
    cycle();
    chk("both_int_hold", {31'b0, obs_hold}, 32'd1);
    set_idle();
    repeat (2) cycle();
    lit_w("both_int_mcause", 12'h342, 32'h8000_0007);
    repeat (2) cycle();

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      rst              = ($urandom_range(0, 99) != 0);
      id_valid         = ($urandom_range(0, 3) != 0);
      id_ecall         = ($urandom_range(0, 9) == 0);
      id_ebreak        = ($urandom_range(0, 11) == 0);
      id_mret          = ($urandom_range(0, 9) == 0);
      interrupt_flag   = ($urandom_range(0, 11) == 0);
      csr_we_ex        = ($urandom_range(0, 3) == 0);
      interrupt_enable = $urandom_range(0, 1) == 1;
      id_pc            = $urandom;
      csr_mstatus      = $urandom;
      csr_mepc         = $urandom;
      csr_mtvec        = $urandom;
      if ($urandom_range(0, 1) == 1) csr_mtvec[1:0] = 2'b01;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clint_trap_ctrl
`default_nettype wire
